mor1kx_spr_gpr_master: RTL



---
 rtl/mor1kx_spr_gpr_master_pkg.sv | 22 ++
 rtl/mor1kx_spr_gpr_master_if.sv | 38 +++
 rtl/mor1kx_spr_timeout_cnt.sv | 25 ++
 rtl/mor1kx_spr_gpr_master.sv | 133 +++++++++++++
 4 files changed

// File: rtl/mor1kx_spr_gpr_master_pkg.sv
// Shared constants, FSM encoding and address helper for the debug-side GPR SPR initiator.
package mor1kx_spr_gpr_master_pkg;

  localparam logic [15:0] SPR_GPR_BASE  = 16'h0400;
  localparam int          SPR_GROUP_LSB = 9;
  localparam int          SPR_GROUP_MSB = 15;
  localparam logic [SPR_GROUP_MSB-SPR_GROUP_LSB:0] SPR_GPR_GROUP =
    SPR_GPR_BASE[SPR_GROUP_MSB:SPR_GROUP_LSB];

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } gpr_state_t;

  // Group 0 GPR window: group field fixed, low 9 bits carry {set, gpr}.
  function automatic logic [15:0] gpr_spr_addr(input logic [SPR_GROUP_LSB-1:0] idx);
    return {SPR_GPR_GROUP, idx};
  endfunction

endpackage

// File: rtl/mor1kx_spr_gpr_master_if.sv
// Debug-request port plus SPR-bus initiator signals of the GPR master.
interface mor1kx_spr_gpr_master_if #(
  parameter int OW = 32,
  parameter int AW = 5
) ();

  logic          du_req_i;
  logic          du_we_i;
  logic [3:0]    du_set_i;
  logic [AW-1:0] du_gpr_i;
  logic [OW-1:0] du_dat_i;
  logic          du_abort_i;
  logic          du_ready_o;
  logic          du_done_o;
  logic          du_err_o;
  logic [OW-1:0] du_dat_o;
  logic [15:0]   spr_bus_addr_o;
  logic          spr_bus_stb_o;
  logic          spr_bus_we_o;
  logic [OW-1:0] spr_bus_dat_o;
  logic          spr_gpr_ack_i;
  logic [OW-1:0] spr_gpr_dat_i;

  modport master (
    input  du_req_i, du_we_i, du_set_i, du_gpr_i, du_dat_i, du_abort_i,
    input  spr_gpr_ack_i, spr_gpr_dat_i,
    output du_ready_o, du_done_o, du_err_o, du_dat_o,
    output spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o
  );

  modport slave (
    output du_req_i, du_we_i, du_set_i, du_gpr_i, du_dat_i, du_abort_i,
    output spr_gpr_ack_i, spr_gpr_dat_i,
    input  du_ready_o, du_done_o, du_err_o, du_dat_o,
    input  spr_bus_addr_o, spr_bus_stb_o, spr_bus_we_o, spr_bus_dat_o
  );

endinterface

// File: rtl/mor1kx_spr_timeout_cnt.sv
// Loadable down-counter; expire flags the last permitted cycle (count == 1).
module mor1kx_spr_timeout_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt,
  output logic             expire
);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - WIDTH'(1);
  end

  assign expire = (cnt == WIDTH'(1));

endmodule

// File: rtl/mor1kx_spr_gpr_master.sv
// Debug-unit GPR access over the SPR bus: request -> range check -> held strobe until ack,
// timeout or abort -> one-cycle done pulse with error flag.
module mor1kx_spr_gpr_master
  import mor1kx_spr_gpr_master_pkg::*;
#(
  parameter int OPTION_OPERAND_WIDTH     = 32,
  parameter int OPTION_RF_ADDR_WIDTH     = 5,
  parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
  parameter int OPTION_SPR_TIMEOUT       = 255
) (
  input logic                    clk,
  input logic                    rst,
  mor1kx_spr_gpr_master_if.master bus
);

  localparam int CW = $clog2(OPTION_SPR_TIMEOUT + 1);

  gpr_state_t state, state_nxt;

  logic                            we_r;
  logic [3:0]                      set_r;
  logic [OPTION_RF_ADDR_WIDTH-1:0] gpr_r;
  logic [OPTION_OPERAND_WIDTH-1:0] wdat_r;
  logic [OPTION_OPERAND_WIDTH-1:0] rdat_r;
  logic [15:0]                     addr_r;
  logic                            err_r;

  logic          accept, cnt_load, cnt_dec, rd_capture, err_load, err_val;
  logic          range_bad, expire;
  logic [CW-1:0] cnt;
  logic [31:0]   idx_wide;

  // Wide index so an out-of-window {set, gpr} is detectable for any address width.
  assign idx_wide  = (32'(set_r) << OPTION_RF_ADDR_WIDTH) | 32'(gpr_r);
  assign range_bad = (32'(set_r) > 32'(OPTION_RF_NUM_SHADOW_GPR)) || (idx_wide > 32'd511);

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    rd_capture = 1'b0;
    err_load   = 1'b0;
    err_val    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.du_req_i) begin
          accept    = 1'b1;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (range_bad) begin
          err_load  = 1'b1;
          err_val   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Ack takes priority over a same-cycle abort or timeout.
        if (bus.spr_gpr_ack_i) begin
          rd_capture = ~we_r;
          err_load   = 1'b1;
          state_nxt  = ST_DONE;
        end else if (bus.du_abort_i || expire) begin
          err_load  = 1'b1;
          err_val   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_r   <= 1'b0;
      set_r  <= '0;
      gpr_r  <= '0;
      wdat_r <= '0;
      rdat_r <= '0;
      addr_r <= '0;
      err_r  <= 1'b0;
    end else begin
      if (accept) begin
        we_r   <= bus.du_we_i;
        set_r  <= bus.du_set_i;
        gpr_r  <= bus.du_gpr_i;
        wdat_r <= bus.du_dat_i;
        rdat_r <= '0;
      end
      if (cnt_load)
        addr_r <= gpr_spr_addr(idx_wide[SPR_GROUP_LSB-1:0]);
      if (rd_capture)
        rdat_r <= bus.spr_gpr_dat_i;
      if (err_load)
        err_r <= err_val;
    end
  end

  mor1kx_spr_timeout_cnt #(.WIDTH(CW)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CW'(OPTION_SPR_TIMEOUT)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .expire   (expire)
  );

  assign bus.du_ready_o     = (state == ST_IDLE);
  assign bus.du_done_o      = (state == ST_DONE);
  assign bus.du_err_o       = (state == ST_DONE) && err_r;
  assign bus.du_dat_o       = rdat_r;
  assign bus.spr_bus_stb_o  = (state == ST_ACCESS);
  assign bus.spr_bus_we_o   = (state == ST_ACCESS) && we_r;
  assign bus.spr_bus_addr_o = addr_r;
  assign bus.spr_bus_dat_o  = wdat_r;

endmodule
